// File: rtl/ct_rtu_preg_alloc_96.sv
// Physical register allocator for 96 entries: offers the lowest-index free
// entry as a registered one-hot and tracks the free pool with a bit vector.
module ct_rtu_preg_alloc_96 (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic        x_alloc_req,
  input  logic        x_dealloc_vld,
  input  logic [95:0] x_dealloc_expand,
  input  logic        x_flush,
  input  logic [95:0] x_flush_free_mask,
  output logic        x_alloc_vld,
  output logic [95:0] x_alloc_expand,
  output logic [6:0]  x_free_cnt
);

  localparam int unsigned NUM_ENTRY = 96;
  localparam int unsigned CNT_W     = 7;

  logic [NUM_ENTRY-1:0] free_vec;
  logic                 alloc_vld;
  logic [NUM_ENTRY-1:0] alloc_expand;

  logic [NUM_ENTRY-1:0] dmask;
  logic [NUM_ENTRY-1:0] pick;
  logic                 take;
  logic [CNT_W-1:0]     free_cnt;

  // Releases are only seen when qualified; the lowest free bit is isolated
  // by two's-complement masking so pick is always zero or one-hot.
  always_comb begin
    dmask = x_dealloc_vld ? x_dealloc_expand : '0;
    take  = ~alloc_vld | x_alloc_req;
    pick  = free_vec & (~free_vec + NUM_ENTRY'(1));
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      free_vec     <= '1;
      alloc_vld    <= 1'b0;
      alloc_expand <= '0;
    end else if (x_flush) begin
      free_vec     <= x_flush_free_mask;
      alloc_vld    <= 1'b0;
      alloc_expand <= '0;
    end else if (take) begin
      // Same-cycle releases land in free_vec only; they are not bypassed to pick.
      if (pick != '0) begin
        alloc_vld    <= 1'b1;
        alloc_expand <= pick;
        free_vec     <= (free_vec & ~pick) | dmask;
      end else begin
        alloc_vld    <= 1'b0;
        alloc_expand <= '0;
        free_vec     <= free_vec | dmask;
      end
    end else begin
      free_vec <= free_vec | dmask;
    end
  end

  // Population count of the pool; the offered entry is already removed from it.
  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < NUM_ENTRY; i++) begin
      free_cnt = free_cnt + CNT_W'(free_vec[i]);
    end
  end

  assign x_alloc_vld    = alloc_vld;
  assign x_alloc_expand = alloc_expand;
  assign x_free_cnt     = free_cnt;

endmodule

// File: tb/tb_ct_rtu_preg_alloc_96.sv
// Bench for ct_rtu_preg_alloc_96: directed scenarios plus random traffic,
// checked each cycle against an array-based model of the free pool.
module tb_ct_rtu_preg_alloc_96;

  logic        clk;
  logic        rst;
  logic        req;
  logic        dvld;
  logic [95:0] dexp;
  logic        flush;
  logic [95:0] fmask;
  logic        vld;
  logic [95:0] expand;
  logic [6:0]  cnt;

  int tests;
  int failed;

  // Reference model: one flag per entry plus the currently offered index.
  bit ref_free[96];
  bit ref_vld;
  int ref_idx;

  ct_rtu_preg_alloc_96 dut (
    .forever_cpuclk   (clk),
    .cpurst           (rst),
    .x_alloc_req      (req),
    .x_dealloc_vld    (dvld),
    .x_dealloc_expand (dexp),
    .x_flush          (flush),
    .x_flush_free_mask(fmask),
    .x_alloc_vld      (vld),
    .x_alloc_expand   (expand),
    .x_free_cnt       (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_count();
    int n = 0;
    for (int i = 0; i < 96; i++) if (ref_free[i]) n++;
    return n;
  endfunction

  function automatic logic [95:0] ref_expand();
    logic [95:0] e = '0;
    if (ref_vld) e[ref_idx] = 1'b1;
    return e;
  endfunction

  task automatic model_step();
    int lo = -1;
    if (rst) begin
      for (int i = 0; i < 96; i++) ref_free[i] = 1'b1;
      ref_vld = 1'b0;
    end else if (flush) begin
      for (int i = 0; i < 96; i++) ref_free[i] = fmask[i];
      ref_vld = 1'b0;
    end else begin
      for (int i = 95; i >= 0; i--) if (ref_free[i]) lo = i;
      if (!ref_vld || req) begin
        if (lo >= 0) begin
          ref_free[lo] = 1'b0;
          ref_vld = 1'b1;
          ref_idx = lo;
        end else begin
          ref_vld = 1'b0;
        end
      end
      if (dvld) for (int i = 0; i < 96; i++) if (dexp[i]) ref_free[i] = 1'b1;
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [6:0] obs, input int exp);
    tests++;
    assert (obs === 7'(exp)) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk_bit({tag, "_vld"}, vld, ref_vld);
    chk_vec({tag, "_expand"}, expand, ref_expand());
    chk_cnt({tag, "_cnt"}, cnt, ref_count());
  endtask

  // Drive one cycle of inputs, advance model and DUT, then compare.
  task automatic cyc(input logic r, input logic rq, input logic dv, input logic [95:0] dm,
                     input logic fl, input logic [95:0] fm, input string tag);
    rst = r; req = rq; dvld = dv; dexp = dm; flush = fl; fmask = fm;
    model_step();
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  task automatic idle(input string tag);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, tag);
  endtask

  logic [95:0] onehot;
  logic [95:0] m;

  initial begin
    tests = 0; failed = 0;
    ref_vld = 1'b0; ref_idx = 0;
    for (int i = 0; i < 96; i++) ref_free[i] = 1'b0;
    rst = 1'b1; req = 1'b0; dvld = 1'b0; dexp = '0; flush = 1'b0; fmask = '0;

    // Reset state
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, '0, "reset0");
    cyc(1'b1, 1'b1, 1'b1, '1, 1'b1, '0, "reset1");
    chk_bit("reset_vld", vld, 1'b0);
    chk_vec("reset_expand", expand, '0);
    chk_cnt("reset_cnt", cnt, 96);

    // First edge after release offers entry 0 and holds it with req=0
    idle("release");
    onehot = 96'd1;
    chk_bit("release_vld", vld, 1'b1);
    chk_vec("release_expand", expand, onehot);
    chk_cnt("release_cnt", cnt, 95);
    for (int i = 0; i < 5; i++) idle("hold");
    chk_vec("hold_expand", expand, onehot);

    // Back-to-back grants drain all 96 entries in order
    for (int i = 1; i < 96; i++) begin
      cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, "drain");
      onehot = '0; onehot[i] = 1'b1;
      chk_vec("drain_order", expand, onehot);
    end
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, "drain_last");
    chk_bit("empty_vld", vld, 1'b0);
    chk_vec("empty_expand", expand, '0);
    chk_cnt("empty_cnt", cnt, 0);

    // Release of entry 40 while empty becomes visible one edge later
    m = '0; m[40] = 1'b1;
    cyc(1'b0, 1'b1, 1'b1, m, 1'b0, '0, "dealloc40_n");
    chk_bit("dealloc40_n_vld", vld, 1'b0);
    chk_cnt("dealloc40_n_cnt", cnt, 1);
    idle("dealloc40_n1");
    chk_vec("dealloc40_n1_expand", expand, m);
    chk_cnt("dealloc40_n1_cnt", cnt, 0);

    // Offer bit 5, release 3 and 70 without req, then next offer is 3
    m = '0; m[5] = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, m, "flush5");
    idle("offer5");
    chk_vec("offer5_expand", expand, m);
    chk_cnt("offer5_cnt", cnt, 0);
    onehot = '0; onehot[3] = 1'b1; onehot[70] = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, onehot, 1'b0, '0, "dealloc3_70");
    chk_vec("dealloc3_70_expand", expand, m);
    chk_cnt("dealloc3_70_cnt", cnt, 2);
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0, '0, "next3");
    onehot = '0; onehot[3] = 1'b1;
    chk_vec("next3_expand", expand, onehot);

    // Flush to upper 64 entries overrides concurrent req and dealloc
    m = '0; m[95:32] = '1;
    onehot = 96'd1;
    cyc(1'b0, 1'b1, 1'b1, onehot, 1'b1, m, "flush_hi");
    chk_bit("flush_hi_vld", vld, 1'b0);
    chk_cnt("flush_hi_cnt", cnt, 64);
    idle("flush_hi_n1");
    onehot = '0; onehot[32] = 1'b1;
    chk_vec("flush_hi_n1_expand", expand, onehot);
    chk_cnt("flush_hi_n1_cnt", cnt, 63);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic r, rq, dv, fl;
      logic [95:0] dm, fm;
      dm = {$urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom}
         & {$urandom, $urandom, $urandom};
      fm = {$urandom, $urandom, $urandom};
      r  = ($urandom_range(0, 99) == 0);
      fl = ($urandom_range(0, 39) == 0);
      rq = ($urandom_range(0, 3) != 0);
      dv = ($urandom_range(0, 2) == 0);
      cyc(r, rq, dv, dm, fl, fm, "rand");
    end

    // Reset mid-stream beats req, dealloc and flush
    cyc(1'b1, 1'b1, 1'b1, '1, 1'b1, '0, "midrst");
    chk_bit("midrst_vld", vld, 1'b0);
    chk_vec("midrst_expand", expand, '0);
    chk_cnt("midrst_cnt", cnt, 96);
    idle("midrst_rel");
    chk_vec("midrst_rel_expand", expand, 96'd1);
    chk_cnt("midrst_rel_cnt", cnt, 95);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
